// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a word-organised memory with a combinational read and a synchronous write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise the low address bits are forced to alignment.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_fault,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_writeData,
    input  logic [31:0]           mem_readData
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
    state_t state;
    logic [2:0] f3;
    logic [1:0] lo;
    logic [31:0] wbuf, load_data, merged, mask;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [4:0] sh;
    logic illegal, oor, misal, fault;
    always_comb begin
        illegal = req_funct3[1:0] == 2'b11 || (req_funct3[2] && (req_is_store || req_funct3[1]));
        oor = (req_addr >> 2) >= ADDR_WIDTH'(MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        fault = illegal || oor || misal;
        byte_v = mem_readData[{lo, 3'b000} +: 8];
        half_v = lo[1] ? mem_readData[31:16] : mem_readData[15:0];
        load_data = f3[1] ? mem_readData :
                    f3[0] ? {{16{~f3[2] & half_v[15]}}, half_v} : {{24{~f3[2] & byte_v[7]}}, byte_v};
        // halfword lanes only look at addr[1], which realigns SH/LH when traps are off
        sh = f3[0] ? {lo[1], 4'b0000} : {lo, 3'b000};
        mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged = (mem_readData & ~mask) | ((wbuf << sh) & mask);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            f3 <= 3'b000;
            lo <= 2'b00;
            wbuf <= 32'h0;
            mem_addr <= '0;
            resp_data <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (fault) begin
                        resp_fault <= 1'b1;
                        resp_data <= 32'h0;
                        state <= RESP;
                    end else begin
                        f3 <= req_funct3;
                        lo <= req_addr[1:0];
                        mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        wbuf <= req_wdata;
                        state <= !req_is_store ? LOAD : req_funct3[1] ? WRITE : RMW_RD;
                    end
                end
                LOAD: begin
                    resp_data <= load_data;
                    resp_fault <= 1'b0;
                    state <= RESP;
                end
                RMW_RD: begin
                    wbuf <= merged;
                    state <= WRITE;
                end
                WRITE: begin
                    resp_data <= 32'h0;
                    resp_fault <= 1'b0;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    assign MemRead = state == LOAD || state == RMW_RD;
    assign MemWrite = state == WRITE;
    assign mem_writeData = wbuf;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a behavioural word memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0] req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic resp_valid, resp_fault, MemRead, MemWrite;
    logic [31:0] resp_data, mem_addr, mem_writeData, mem_readData;
    logic [31:0] mem [0:1023];
    int checks = 0, errors = 0;
    int lat, nrd, nwr, both = 0;
    logic [31:0] wseen;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_fault(resp_fault), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_writeData(mem_writeData), .mem_readData(mem_readData)
    );

    assign mem_readData = mem[mem_addr[11:2]];
    always @(posedge clk) if (MemWrite) mem[mem_addr[11:2]] <= mem_writeData;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        issue(st, f, a, wd);
        lat = 1; nrd = 0; nwr = 0; wseen = 32'h0;
        while (!resp_valid && lat < 10) begin
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                wseen = mem_writeData;
            end
            if (MemRead && MemWrite) both++;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        do_req(1'b0, f, a, 32'h0);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_fault"}, {31'b0, resp_fault}, 32'h0);
    endtask

    initial begin
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_writeData, 32'h0);
        check("rst_resp", {resp_data[30:0], resp_fault}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F81);
        check("sw10_lat", lat, 2);
        check("sw10_rd", nrd, 0);
        check("sw10_wr", nwr, 1);
        check("sw10_wdata", wseen, 32'h80FF7F81);
        load_chk("lb13", 3'b000, 32'h13, 32'hFFFFFF80);
        load_chk("lbu11", 3'b100, 32'h11, 32'h0000007F);
        load_chk("lhu12", 3'b101, 32'h12, 32'h000080FF);
        load_chk("lh12", 3'b001, 32'h12, 32'hFFFF80FF);
        load_chk("lw10", 3'b010, 32'h10, 32'h80FF7F81);

        do_req(1'b1, 3'b010, 32'h10, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h12, 32'h000000AB);
        check("sb12_lat", lat, 3);
        check("sb12_rd", nrd, 1);
        check("sb12_wr", nwr, 1);
        check("sb12_wdata", wseen, 32'h11AB3344);
        check("sb12_data", resp_data, 32'h0);
        load_chk("lw10_sb", 3'b010, 32'h10, 32'h11AB3344);
        do_req(1'b1, 3'b001, 32'h10, 32'h5555BEEF);
        check("sh10_lat", lat, 3);
        check("sh10_wdata", wseen, 32'h11ABBEEF);

        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        check("sw20_rd", nrd, 0);
        check("sw20_wr", nwr, 1);
        load_chk("lw20", 3'b010, 32'h20, 32'hDEADBEEF);

        do_req(1'b0, 3'b010, 32'h22, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw22_fault", {31'b0, resp_fault}, 32'h1);
        check("lw22_lat", lat, 1);
        check("lw22_strobes", nrd + nwr, 0);
        check("lw22_data", resp_data, 32'h0);
`else
        check("lw22_fault", {31'b0, resp_fault}, 32'h0);
        check("lw22_lat", lat, 2);
        check("lw22_data", resp_data, 32'hDEADBEEF);
`endif
        do_req(1'b0, 3'b000, 32'h1000, 32'h0);
        check("lb1000_fault", {31'b0, resp_fault}, 32'h1);
        check("lb1000_lat", lat, 1);
        check("lb1000_strobes", nrd + nwr, 0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        check("ld011_fault", {31'b0, resp_fault}, 32'h1);
        do_req(1'b1, 3'b100, 32'h10, 32'h0);
        check("st100_fault", {31'b0, resp_fault}, 32'h1);
        check("st100_wr", nwr, 0);

        issue(1'b0, 3'b010, 32'h10, 32'h0);
        check("mid_rd", {31'b0, MemRead}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_ready", {31'b0, req_ready}, 32'h1);
        check("mid_valid", {31'b0, resp_valid}, 32'h0);
        check("mid_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h14, 32'hCAFEBABE);
        issue(1'b1, 3'b001, 32'h16, 32'h00001234);
        check("sh16_rd", {31'b0, MemRead}, 32'h1);
        @(posedge clk);
        #1;
        check("sh16_wr", {31'b0, MemWrite}, 32'h1);
        check("sh16_wdata", mem_writeData, 32'h1234BABE);
        rst_n = 1'b0;
        #1;
        check("sh16_wr_drop", {31'b0, MemWrite}, 32'h0);
        @(posedge clk);
        #1;
        check("sh16_mem", mem[5], 32'hCAFEBABE);
        check("sh16_valid", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load_chk("lw14", 3'b010, 32'h14, 32'hCAFEBABE);

        check("never_both", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
